// File: rtl/exp_unit_pkg.sv
// Shared definitions for the fixed-point exponential unit (e^x for the softmax stage).
// Contents: datapath widths, log2(e) constant, 2^f polynomial coefficients, FSM state type.
// No ports; imported by exp_unit_if, exp_pow2_frac and exp_unit.
package definition;

  // Attention datapath half-width; data ports are 2*att_width bits.
  localparam int unsigned att_width = 8;
  localparam int unsigned FRAC      = att_width;
  localparam int unsigned DW        = 2 * att_width;

  // log2(e) in Q2.14.
  localparam int          LOG2E      = 23637;
  localparam int unsigned LOG2E_FRAC = 14;

  // 2^f ~= 1 + f*(C1 + C2*f), coefficients in Q0.(FRAC+2), rounded to nearest.
  // C1 + C2 == 1.0 exactly, so the curve meets 2.0 at f -> 1.
  localparam int unsigned C1 = (6565 * (1 << (FRAC + 2)) + 5000) / 10000;
  localparam int unsigned C2 = (3435 * (1 << (FRAC + 2)) + 5000) / 10000;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    POW,
    SHIFT,
    DONE
  } exp_state_t;

endpackage

// File: rtl/exp_unit_if.sv
// Start/done bus of the exponential unit.
//   en       : start/hold request (master -> slave)
//   i_exp    : operand x, signed Q(DW-FRAC).FRAC (master -> slave)
//   o_exp    : result e^x, unsigned Q(DW-FRAC).FRAC, held between results (slave -> master)
//   end_flag : one-cycle pulse when o_exp is updated (slave -> master)
interface exp_unit_if;
  import definition::*;

  logic                 en;
  logic signed [DW-1:0] i_exp;
  logic        [DW-1:0] o_exp;
  logic                 end_flag;

  modport master (
    output en,
    output i_exp,
    input  o_exp,
    input  end_flag
  );

  modport slave (
    input  en,
    input  i_exp,
    output o_exp,
    output end_flag
  );

endinterface

// File: rtl/exp_pow2_frac.sv
// Combinational 2^f approximation for f in [0,1).
//   f_i : fraction, Q0.FRAC
//   m_o : 2^f, Q1.FRAC (range [1.0, 2.0))
// Evaluates 1 + f*(C1 + C2*f) with round-to-nearest at each rescale.
module exp_pow2_frac
  import definition::*;
(
  input  logic [FRAC-1:0] f_i,
  output logic [FRAC:0]   m_o
);

  // Coefficient width: Q0.(FRAC+2) needs one extra bit to hold 1.0.
  localparam int unsigned CW = FRAC + 3;
  localparam int unsigned PW = CW + FRAC;

  logic [PW-1:0] c2f;
  logic [CW-1:0] inner;
  logic [PW-1:0] prod;

  always_comb begin
    // C2*f is Q0.(2*FRAC+2); drop FRAC bits to return to coefficient scale.
    c2f   = PW'(C2) * PW'(f_i);
    inner = CW'(PW'(C1) + ((c2f + PW'(1 << (FRAC - 1))) >> FRAC));
    // f*inner is Q0.(2*FRAC+2); drop FRAC+2 bits to get a Q0.FRAC increment.
    prod  = PW'(f_i) * PW'(inner);
    m_o   = (FRAC + 1)'(PW'(1 << FRAC) + ((prod + PW'(1 << (FRAC + 1))) >> (FRAC + 2)));
  end

endmodule

// File: rtl/exp_unit.sv
// Fixed-point exponential unit: o_exp = e^x computed as 2^(x*log2e).
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : exp_unit_if.slave (en, i_exp in; o_exp, end_flag out)
// Sequence IDLE -> MUL -> POW -> SHIFT -> DONE; end_flag pulses in SHIFT, three cycles after
// en is sampled in IDLE. Dropping en in MUL or POW aborts without touching o_exp.
// Build option EXP_SAT_EN: when defined, results >= 2^DW saturate to all-ones; otherwise the
// left shift is truncated to DW bits. Underflow to zero is present in both builds.
module exp_unit
  import definition::*;
(
  input  logic       clk,
  input  logic       rstn,
  exp_unit_if.slave  bus
);

  localparam int unsigned SW = $clog2(DW);

  // Shift-count thresholds on n (signed).
  localparam logic signed [DW-1:0] NUfl = DW'(-(int'(FRAC) + 1));  // at or below: result is 0
`ifdef EXP_SAT_EN
  localparam logic signed [DW-1:0] NOvf = DW'(DW - FRAC);          // m >= 1.0 overflows here
`else
  localparam logic signed [DW-1:0] NOut = DW'(DW);                 // everything shifted out
`endif

  exp_state_t           state_q;
  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] n_q, n_d;
  logic [FRAC-1:0]      f_q, f_d;
  logic [DW-1:0]        o_exp_q, r_d;
  logic                 end_flag_q;

  logic signed [31:0]   prod;
  logic signed [31:0]   scaled;
  logic [FRAC:0]        m_w;
  logic [DW-1:0]        m_ext;

  // x * log2(e): Q.FRAC times Q2.14, rounded back to Q.FRAC. The arithmetic shift floors,
  // so n is the floor of the exponent and f is always a non-negative fraction.
  always_comb begin
    prod   = 32'(x_q) * 32'(LOG2E);
    scaled = (prod + (32'sd1 <<< (LOG2E_FRAC - 1))) >>> LOG2E_FRAC;
    n_d    = DW'(scaled >>> FRAC);
    f_d    = scaled[FRAC-1:0];
  end

  exp_pow2_frac u_pow2 (
    .f_i (f_q),
    .m_o (m_w)
  );

  // Barrel shift of the Q1.FRAC mantissa by n; output keeps FRAC fractional bits.
  always_comb begin
    m_ext = DW'(m_w);
    r_d   = '0;
    if (n_q[DW-1]) begin
      if (n_q > NUfl) begin
        r_d = m_ext >> SW'(-n_q);
      end
    end else begin
`ifdef EXP_SAT_EN
      if (n_q >= NOvf) begin
        r_d = '1;
      end else begin
        r_d = m_ext << SW'(n_q);
      end
`else
      if (n_q < NOut) begin
        r_d = m_ext << SW'(n_q);
      end
`endif
    end
  end

  // The polynomial and shifter are evaluated together at the end of POW so the new result
  // and its end_flag pulse are both visible while the FSM sits in SHIFT.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      n_q        <= '0;
      f_q        <= '0;
      o_exp_q    <= '0;
      end_flag_q <= 1'b0;
    end else begin
      end_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            x_q     <= bus.i_exp;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else begin
            n_q     <= n_d;
            f_q     <= f_d;
            state_q <= POW;
          end
        end
        POW: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else begin
            o_exp_q    <= r_d;
            end_flag_q <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          state_q <= DONE;
        end
        DONE: begin
          // No retrigger until en has been released.
          if (!bus.en) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_exp    = o_exp_q;
  assign bus.end_flag = end_flag_q;

endmodule

// File: tb/tb_exp_unit.sv
// Bench for exp_unit: table of starts with expected results queued at stimulus time and
// popped when end_flag fires, plus hand-written reset and abort sequences.
module tb_exp_unit;
  import definition::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  exp_unit_if u_if ();

  exp_unit u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

`ifdef EXP_SAT_EN
  localparam int Ovf1600 = 65535;
`else
  localparam int Ovf1600 = 1536;  // 259 << 9 truncated to 16 bits
`endif

  typedef struct {
    int x;
    int exp_val;
    int tol;
    int hold;
    bit done;
  } vec_t;

  typedef struct {
    int exp_val;
    int tol;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_val = 0;
  int   last_tol = 0;

  task automatic chk(input string name, input int act, input int req, input int tol);
    int diff;
    n_cmp++;
    diff = (act > req) ? act - req : req - act;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (tol %0d) at %0t", name, act, req, tol, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One observed cycle; k counts cycles since en was raised.
  task automatic observe(input int k, inout int pulses);
    sb_t e;
    if (u_if.end_flag === 1'b1) begin
      pulses++;
      chk("latency", k, 3, 0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: got unexpected end_flag, required none at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("o_exp", int'(u_if.o_exp), e.exp_val, e.tol);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int pulses = 0;
    u_if.i_exp = DW'(v.x);
    u_if.en    = 1'b1;
    if (v.done) sb_q.push_back('{exp_val: v.exp_val, tol: v.tol});
    for (int k = 1; k <= v.hold; k++) begin
      tick();
      // Operand must only be sampled in IDLE.
      u_if.i_exp = 16'sh7fff;
      observe(k, pulses);
    end
    u_if.en = 1'b0;
    for (int k = v.hold + 1; k <= v.hold + 2; k++) begin
      tick();
      observe(k, pulses);
    end
    chk("pulse_count", pulses, v.done ? 1 : 0, 0);
    if (v.done) begin
      last_val = v.exp_val;
      last_tol = v.tol;
    end
    chk("o_exp_hold", int'(u_if.o_exp), last_val, last_tol);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{x: 10,    exp_val: 266,     tol: 2, hold: 5, done: 1'b1};
    vecs[1] = '{x: 20,    exp_val: 277,     tol: 2, hold: 5, done: 1'b1};
    vecs[2] = '{x: 30,    exp_val: 288,     tol: 2, hold: 5, done: 1'b1};
    vecs[3] = '{x: 0,     exp_val: 256,     tol: 0, hold: 5, done: 1'b1};
    vecs[4] = '{x: -256,  exp_val: 94,      tol: 2, hold: 5, done: 1'b1};
    vecs[5] = '{x: -4096, exp_val: 0,       tol: 0, hold: 5, done: 1'b1};
    vecs[6] = '{x: 1600,  exp_val: Ovf1600, tol: 0, hold: 5, done: 1'b1};
    vecs[7] = '{x: 100,   exp_val: 0,       tol: 0, hold: 1, done: 1'b0};  // abort in MUL
    vecs[8] = '{x: -100,  exp_val: 0,       tol: 0, hold: 2, done: 1'b0};  // abort in POW
    vecs[9] = '{x: 10,    exp_val: 266,     tol: 2, hold: 5, done: 1'b1};

    u_if.en    = 1'b0;
    u_if.i_exp = '0;
    rstn       = 1'b0;
    tick();
    tick();
    chk("rst_o_exp", int'(u_if.o_exp), 0, 0);
    chk("rst_end_flag", int'(u_if.end_flag), 0, 0);

    rstn   = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (u_if.end_flag === 1'b1) pulses++;
    end
    chk("idle_no_pulse", pulses, 0, 0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end
    chk("sb_drained", sb_q.size(), 0, 0);

    // Reset while the result is being presented in SHIFT.
    u_if.i_exp = 16'sd30;
    u_if.en    = 1'b1;
    tick();
    tick();
    tick();
    chk("shift_end_flag", int'(u_if.end_flag), 1, 0);
    chk("shift_o_exp", int'(u_if.o_exp), 288, 2);
    rstn    = 1'b0;
    u_if.en = 1'b0;
    tick();
    chk("midrst_o_exp", int'(u_if.o_exp), 0, 0);
    chk("midrst_end_flag", int'(u_if.end_flag), 0, 0);
    rstn   = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (u_if.end_flag === 1'b1) pulses++;
    end
    chk("postrst_no_pulse", pulses, 0, 0);
    chk("postrst_o_exp", int'(u_if.o_exp), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
